// File: rtl/pet_video_fetch.sv
// Character-slot video fetch for a PET-style display: reads the character code from
// VRAM, looks up the glyph row in the character ROM, and shifts it out one slot later.
module pet_video_fetch #(
    parameter int MA_WIDTH = 11,
    parameter int ROW_BITS = 3,
    parameter int CHAR_AW  = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce_1m,
    input  logic                ce_8mp,
    input  logic                ce_8mn,
    input  logic                cols80,
    input  logic [13:0]         ma,
    input  logic [4:0]          ra,
    input  logic                de,
    input  logic                gfx,
    input  logic                blank,
    input  logic                blank_en,
    output logic [MA_WIDTH-1:0] vram_addr,
    output logic                vram_rd,
    input  logic [7:0]          vram_data,
    output logic [CHAR_AW-1:0]  char_addr,
    input  logic [7:0]          char_data,
    output logic                pix,
    output logic                busy
);

    // state | meaning
    // IDLE  | no fetch in progress, CPU owns VRAM
    // VAk   | VRAM read of character code k
    // CAk   | code on vram_data, character ROM address driven
    // STk   | ROM row on char_data, stored into holding register k
    typedef enum logic [2:0] {IDLE, VA0, CA0, ST0, VA1, CA1, ST1} state_t;

    state_t      state;
    logic [13:0] ma_l;
    logic [4:0]  ra_l;
    logic        gfx_l;
    logic        c80_l;
    logic [7:0]  h0;
    logic [7:0]  h1;
    logic        inv0;
    logic        inv1;
    logic        inv_pend;
    logic [7:0]  snap_h0;
    logic [7:0]  snap_h1;
    logic        snap_i0;
    logic        snap_i1;
    logic [7:0]  shifter;
    logic        inv;
    logic [4:0]  step_cnt;
    logic        start;
    logic        mode80;
    logic        step;
    logic [4:0]  idx;
    logic        unused_bits;

    assign start       = de & ~(|ra[4:ROW_BITS]);
    assign unused_bits = ^{ma_l, ra_l};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            vram_rd   <= 1'b0;
            vram_addr <= '0;
            ma_l      <= '0;
            ra_l      <= '0;
            gfx_l     <= 1'b0;
            c80_l     <= 1'b0;
            h0        <= '0;
            h1        <= '0;
            inv0      <= 1'b0;
            inv1      <= 1'b0;
            inv_pend  <= 1'b0;
        end else if (ce_1m) begin
            // a new slot always wins, aborting any fetch still in flight
            ma_l   <= ma;
            ra_l   <= ra;
            gfx_l  <= gfx;
            c80_l  <= cols80;
            if (start) begin
                state     <= VA0;
                busy      <= 1'b1;
                vram_rd   <= 1'b1;
                vram_addr <= cols80 ? {ma[MA_WIDTH-2:0], 1'b0} : ma[MA_WIDTH-1:0];
            end else begin
                state   <= IDLE;
                busy    <= 1'b0;
                vram_rd <= 1'b0;
                h0      <= '0;
                h1      <= '0;
                inv0    <= 1'b0;
                inv1    <= 1'b0;
            end
        end else begin
            case (state)
                VA0: begin
                    state   <= CA0;
                    vram_rd <= 1'b0;
                end
                CA0: begin
                    state    <= ST0;
                    inv_pend <= vram_data[7] ^ ma_l[12];
                end
                ST0: begin
                    h0   <= char_data;
                    inv0 <= inv_pend;
                    if (c80_l) begin
                        state     <= VA1;
                        vram_rd   <= 1'b1;
                        vram_addr <= {ma_l[MA_WIDTH-2:0], 1'b1};
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                VA1: begin
                    state   <= CA1;
                    vram_rd <= 1'b0;
                end
                CA1: begin
                    state    <= ST1;
                    inv_pend <= vram_data[7] ^ ma_l[12];
                end
                ST1: begin
                    h1    <= char_data;
                    inv1  <= inv_pend;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    vram_rd <= 1'b0;
                end
            endcase
        end
    end

    assign char_addr = (state == CA0 || state == CA1)
                     ? {ma_l[13], gfx_l, vram_data[6:0], ra_l[ROW_BITS-1:0]} : '0;

    // ce_1m coinciding with a step makes that step the first of the new slot
    assign mode80 = ce_1m ? cols80 : c80_l;
    assign step   = ce_8mn | (mode80 & ce_8mp);
    assign idx    = ce_1m ? 5'd0 : step_cnt;

    // Snapshots taken at ce_1m keep the previous slot's glyphs stable while the
    // current slot's fetch overwrites the holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_h0  <= '0;
            snap_h1  <= '0;
            snap_i0  <= 1'b0;
            snap_i1  <= 1'b0;
            shifter  <= '0;
            inv      <= 1'b0;
            step_cnt <= '0;
        end else begin
            if (ce_1m) begin
                snap_h0 <= h0;
                snap_h1 <= h1;
                snap_i0 <= inv0;
                snap_i1 <= inv1;
            end
            if (step) begin
                if (idx == 5'd0) begin
                    shifter <= ce_1m ? h0 : snap_h0;
                    inv     <= ce_1m ? inv0 : snap_i0;
                end else if (mode80 && idx == 5'd8) begin
                    shifter <= snap_h1;
                    inv     <= snap_i1;
                end else begin
                    shifter <= {shifter[6:0], 1'b0};
                end
                step_cnt <= (idx != 5'd31) ? idx + 5'd1 : idx;
            end else if (ce_1m) begin
                step_cnt <= '0;
            end
        end
    end

    assign pix = (shifter[7] ^ inv) & ~(blank & blank_en);

endmodule
